// File: rtl/iob_aclint.sv
// RISC-V ACLINT (MSWI, MTIMER, SSWI) for N_HARTS harts behind a single IOb slave port.
// mtime advances on a prescaled clk_i tick or on synchronised rising edges of rtc_i.
module iob_aclint #(
  parameter int N_HARTS  = 1,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int TICK_DIV = 100,
  parameter int RTC_EN   = 0
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  cke_i,
  input  logic                  iob_avalid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic                  iob_rvalid_o,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  iob_ready_o,
  input  logic                  rtc_i,
  input  logic                  halt_i,
  output logic [N_HARTS-1:0]    mtip_o,
  output logic [N_HARTS-1:0]    msip_o,
  output logic [N_HARTS-1:0]    ssip_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]      presc;
  logic [2:0]         rtc_sync;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp [N_HARTS];
  logic [N_HARTS-1:0] msip;
  logic [N_HARTS-1:0] mtip;
  logic [N_HARTS-1:0] ssip;
  logic               ready;
  logic               rvalid;
  logic [DATA_W-1:0]  rdata;

  logic               wr;
  logic               rd;
  logic [N_HARTS-1:0] msip_sel;
  logic [N_HARTS-1:0] cmp_lo_sel;
  logic [N_HARTS-1:0] cmp_hi_sel;
  logic [N_HARTS-1:0] ssip_sel;
  logic               mt_lo_sel;
  logic               mt_hi_sel;
  logic [DATA_W-1:0]  rmux;
  logic               presc_tick;
  logic               rtc_tick;
  logic               tick;

  // Each set strobe bit replaces one byte of the addressed word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wd,
                                                   input logic [DATA_W/8-1:0] st);
    logic [DATA_W-1:0] res;
    res = old;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (st[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  assign wr = iob_avalid_i && ready && (iob_wstrb_i != '0);
  assign rd = iob_avalid_i && ready && (iob_wstrb_i == '0);

  // Full-address match, so misaligned addresses fall into the unmapped space.
  always_comb begin
    msip_sel   = '0;
    cmp_lo_sel = '0;
    cmp_hi_sel = '0;
    ssip_sel   = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      msip_sel[h]   = (iob_addr_i == ADDR_W'(4 * h));
      cmp_lo_sel[h] = (iob_addr_i == ADDR_W'(32'h4000 + 8 * h));
      cmp_hi_sel[h] = (iob_addr_i == ADDR_W'(32'h4004 + 8 * h));
      ssip_sel[h]   = (iob_addr_i == ADDR_W'(32'hC000 + 4 * h));
    end
    mt_lo_sel = (iob_addr_i == ADDR_W'(32'hBFF8));
    mt_hi_sel = (iob_addr_i == ADDR_W'(32'hBFFC));
  end

  always_comb begin
    rmux = '0;
    for (int h = 0; h < N_HARTS; h++) begin
      if (msip_sel[h])   rmux = {{(DATA_W-1){1'b0}}, msip[h]};
      if (cmp_lo_sel[h]) rmux = mtimecmp[h][31:0];
      if (cmp_hi_sel[h]) rmux = mtimecmp[h][63:32];
    end
    if (mt_lo_sel) rmux = mtime[31:0];
    if (mt_hi_sel) rmux = mtime[63:32];
  end

  assign presc_tick = (presc == PW'(TICK_DIV - 1));
  assign rtc_tick   = rtc_sync[1] & ~rtc_sync[2];
  assign tick       = ((RTC_EN != 0) ? rtc_tick : presc_tick) & ~halt_i;

  // Time base stage: prescaler and rtc_i synchroniser with edge history flop.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      presc    <= '0;
      rtc_sync <= '0;
    end else if (cke_i) begin
      rtc_sync <= {rtc_sync[1:0], rtc_i};
      if (!halt_i) presc <= presc_tick ? '0 : presc + 1'b1;
    end
  end

  // A write to either mtime word takes priority and swallows a coincident tick.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mtime <= '0;
    end else if (cke_i) begin
      if (wr && (mt_lo_sel || mt_hi_sel)) begin
        if (mt_lo_sel) mtime[31:0]  <= byte_merge(mtime[31:0], iob_wdata_i, iob_wstrb_i);
        if (mt_hi_sel) mtime[63:32] <= byte_merge(mtime[63:32], iob_wdata_i, iob_wstrb_i);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

  // Per-hart register stage: compare values, software interrupts, timer compare.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
      msip <= '0;
      mtip <= '0;
      ssip <= '0;
    end else if (cke_i) begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (wr && cmp_lo_sel[h])
          mtimecmp[h][31:0] <= byte_merge(mtimecmp[h][31:0], iob_wdata_i, iob_wstrb_i);
        if (wr && cmp_hi_sel[h])
          mtimecmp[h][63:32] <= byte_merge(mtimecmp[h][63:32], iob_wdata_i, iob_wstrb_i);
        if (wr && msip_sel[h] && iob_wstrb_i[0]) msip[h] <= iob_wdata_i[0];
        ssip[h] <= wr && ssip_sel[h] && iob_wstrb_i[0] && iob_wdata_i[0];
        mtip[h] <= (mtime >= mtimecmp[h]);
      end
    end
  end

  // Bus response stage: single-cycle read data and permanent ready.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready  <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (cke_i) begin
      ready  <= 1'b1;
      rvalid <= rd;
      if (rd) rdata <= rmux;
    end
  end

  assign iob_ready_o  = ready;
  assign iob_rvalid_o = rvalid;
  assign iob_rdata_o  = rdata;
  assign mtip_o       = mtip;
  assign msip_o       = msip;
  assign ssip_o       = ssip;

endmodule

// File: tb/tb_iob_aclint.sv
// Bench for iob_aclint: three instances (4 harts /4 prescale, 2 harts /1 prescale, RTC time base)
// sharing one bus driver; the 4-hart instance is tracked cycle by cycle against a behavioural model.
module tb_iob_aclint;

  localparam int A_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic        avalid;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        halt;
  logic        rtc;
  logic [1:0]  sel;

  logic        av_a, av_b, av_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        ready_a, ready_b, ready_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [3:0]  mtip_a, msip_a, ssip_a;
  logic [1:0]  mtip_b, msip_b, ssip_b;
  logic        mtip_c, msip_c, ssip_c;
  logic [31:0] rdata_s;
  logic        rvalid_s;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  assign av_a     = avalid && (sel == 2'd0);
  assign av_b     = avalid && (sel == 2'd1);
  assign av_c     = avalid && (sel == 2'd2);
  assign rdata_s  = (sel == 2'd0) ? rdata_a  : (sel == 2'd1) ? rdata_b  : rdata_c;
  assign rvalid_s = (sel == 2'd0) ? rvalid_a : (sel == 2'd1) ? rvalid_b : rvalid_c;

  iob_aclint #(.N_HARTS(4), .ADDR_W(16), .DATA_W(32), .TICK_DIV(A_DIV), .RTC_EN(0)) dut_a (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_a), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rvalid_o(rvalid_a), .iob_rdata_o(rdata_a),
    .iob_ready_o(ready_a), .rtc_i(rtc), .halt_i(halt), .mtip_o(mtip_a), .msip_o(msip_a),
    .ssip_o(ssip_a));

  iob_aclint #(.N_HARTS(2), .ADDR_W(16), .DATA_W(32), .TICK_DIV(1), .RTC_EN(0)) dut_b (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_b), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rvalid_o(rvalid_b), .iob_rdata_o(rdata_b),
    .iob_ready_o(ready_b), .rtc_i(rtc), .halt_i(halt), .mtip_o(mtip_b), .msip_o(msip_b),
    .ssip_o(ssip_b));

  iob_aclint #(.N_HARTS(1), .ADDR_W(16), .DATA_W(32), .TICK_DIV(3), .RTC_EN(1)) dut_c (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(av_c), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rvalid_o(rvalid_c), .iob_rdata_o(rdata_c),
    .iob_ready_o(ready_c), .rtc_i(rtc), .halt_i(halt), .mtip_o(mtip_c), .msip_o(msip_c),
    .ssip_o(ssip_c));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd,
                                      input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural model of instance A: registers as plain integers, ticks from a count of
  // non-halted clock-enabled cycles since reset.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp [4];
  logic [3:0]  m_msip;
  logic [3:0]  e_mtip, e_ssip;
  logic        e_ready, e_rvalid;
  logic [31:0] e_rdata;
  int          m_cnt;
  logic        m_wr, m_rd;

  assign m_wr = av_a && e_ready && (wstrb != 4'b0);
  assign m_rd = av_a && e_ready && (wstrb == 4'b0);

  function automatic logic [31:0] m_read(input logic [15:0] a);
    if (a[1:0] != 2'b0) return 32'h0;
    if (a < 16'h0010) return {31'b0, m_msip[a[3:2]]};
    if (a >= 16'h4000 && a < 16'h4020)
      return a[2] ? m_cmp[(a - 16'h4000) >> 3][63:32] : m_cmp[(a - 16'h4000) >> 3][31:0];
    if (a == 16'hBFF8) return m_mtime[31:0];
    if (a == 16'hBFFC) return m_mtime[63:32];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime  <= 64'h0;
      for (int h = 0; h < 4; h++) m_cmp[h] <= '1;
      m_msip   <= '0;
      e_mtip   <= '0;
      e_ssip   <= '0;
      e_ready  <= 1'b0;
      e_rvalid <= 1'b0;
      e_rdata  <= '0;
      m_cnt    <= 0;
    end else if (cke) begin
      e_ready  <= 1'b1;
      e_rvalid <= m_rd;
      if (m_rd) e_rdata <= m_read(addr);
      e_ssip <= '0;
      for (int h = 0; h < 4; h++) begin
        e_mtip[h] <= (m_mtime >= m_cmp[h]);
        if (m_wr && addr == 16'(16'hC000 + 4 * h) && wstrb[0] && wdata[0]) e_ssip[h] <= 1'b1;
        if (m_wr && addr == 16'(4 * h) && wstrb[0]) m_msip[h] <= wdata[0];
        if (m_wr && addr == 16'(16'h4000 + 8 * h)) m_cmp[h][31:0] <= mrg(m_cmp[h][31:0], wdata, wstrb);
        if (m_wr && addr == 16'(16'h4004 + 8 * h)) m_cmp[h][63:32] <= mrg(m_cmp[h][63:32], wdata, wstrb);
      end
      if (!halt) m_cnt <= m_cnt + 1;
      if (m_wr && addr == 16'hBFF8) m_mtime <= {m_mtime[63:32], mrg(m_mtime[31:0], wdata, wstrb)};
      else if (m_wr && addr == 16'hBFFC) m_mtime <= {mrg(m_mtime[63:32], wdata, wstrb), m_mtime[31:0]};
      else if (!halt && (m_cnt % A_DIV) == A_DIV - 1) m_mtime <= m_mtime + 64'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_mtip", mtip_a, e_mtip);
      chk("a_msip", msip_a, m_msip);
      chk("a_ssip", ssip_a, e_ssip);
      chk("a_ready", ready_a, e_ready);
      chk("a_rvalid", rvalid_a, e_rvalid);
      if (e_rvalid) chk("a_rdata", rdata_a, e_rdata);
    end
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #1;
    avalid = 1'b1; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    avalid = 1'b0; wstrb = 4'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    avalid = 1'b1; addr = a; wstrb = 4'b0;
    @(posedge clk); #1;
    avalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", rvalid_s, 1'b1);
    d = rdata_s;
  endtask

  task automatic rtc_pulse();
    @(posedge clk); #1 rtc = 1'b1;
    repeat (3) @(posedge clk);
    #1 rtc = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    cke = 1'b1; avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    halt = 1'b0; rtc = 1'b0; sel = 2'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mtip", mtip_a, 4'h0);
    chk("reset_ready", ready_a, 1'b0);
    chk("reset_rvalid", rvalid_a, 1'b0);
    rst_n = 1'b1;

    // Free-running prescaled count, read near cycle 40.
    repeat (38) @(posedge clk);
    rd(16'hBFF8, d);
    chk("t1_mtime_lo_range", (d >= 32'd9 && d <= 32'd10), 1'b1);
    chk("t1_mtime_lo_exact", d, 32'd9);
    rd(16'hBFFC, d);
    chk("t1_mtime_hi", d, 32'd0);

    // Timer compare rise and fall.
    wr(16'hBFF8, 32'h0, 4'hF);
    wr(16'h4000, 32'd10, 4'hF);
    wr(16'h4004, 32'h0, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mtip_a[0]) break;
    end
    chk("t2_mtip_rise", mtip_a, 4'b0001);
    rd(16'hBFF8, d);
    chk("t2_mtime_at_rise", d, 32'd10);
    wr(16'h4004, 32'hFFFF_FFFF, 4'hF);
    chk("t2_mtip_hold", mtip_a[0], 1'b1);
    @(posedge clk); #1;
    chk("t2_mtip_fall", mtip_a[0], 1'b0);

    // Software interrupts and byte strobes.
    wr(16'h0008, 32'h1, 4'b0001);
    chk("t4_msip_set", msip_a, 4'b0100);
    wr(16'h0008, 32'h0, 4'b0010);
    chk("t4_msip_wrong_strobe", msip_a, 4'b0100);
    wr(16'h0004, 32'h1, 4'b0010);
    chk("t4_msip_other", msip_a, 4'b0100);
    rd(16'h0008, d);
    chk("t4_msip_read", d, 32'h1);
    wr(16'hC00C, 32'h1, 4'b0001);
    chk("t4_ssip_pulse", ssip_a, 4'b1000);
    @(posedge clk); #1;
    chk("t4_ssip_end", ssip_a, 4'b0000);
    wr(16'hC000, 32'h1, 4'b1110);
    wr(16'hC004, 32'hFFFF_FFFE, 4'hF);
    rd(16'hC00C, d);
    chk("t4_setssip_read", d, 32'h0);
    wr(16'h4010, 32'h1234_5678, 4'b0101);
    rd(16'h4010, d);
    chk("t4_cmp_bytes", d, 32'hFF34_FF78);

    // Clock enable freeze.
    @(posedge clk); #1 cke = 1'b0;
    repeat (6) @(posedge clk);
    #1 cke = 1'b1;

    // 64-bit wrap with a one-cycle prescaler, stepped under halt.
    sel = 2'd1;
    @(posedge clk); #1 halt = 1'b1;
    wr(16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    rd(16'hBFF8, d);
    chk("t3_lo_fe", d, 32'hFFFF_FFFE);
    rd(16'hBFFC, d);
    chk("t3_hi_ff", d, 32'hFFFF_FFFF);
    @(posedge clk); #1 halt = 1'b0;
    @(posedge clk); #1 halt = 1'b1;
    rd(16'hBFF8, d);
    chk("t3_lo_ff", d, 32'hFFFF_FFFF);
    chk("t3_mtip_max", mtip_b, 2'b11);
    @(posedge clk); #1 halt = 1'b0;
    @(posedge clk); #1 halt = 1'b1;
    rd(16'hBFF8, d);
    chk("t3_lo_wrap", d, 32'h0);
    rd(16'hBFFC, d);
    chk("t3_hi_wrap", d, 32'h0);
    chk("t3_mtip_wrap", mtip_b, 2'b00);
    @(posedge clk); #1 halt = 1'b0;

    // RTC time base with halt.
    sel = 2'd2;
    for (int i = 0; i < 5; i++) rtc_pulse();
    repeat (4) @(posedge clk);
    rd(16'hBFF8, d);
    chk("t5_rtc_count", d, 32'd5);
    @(posedge clk); #1 halt = 1'b1;
    for (int i = 0; i < 3; i++) rtc_pulse();
    repeat (4) @(posedge clk);
    rd(16'hBFF8, d);
    chk("t5_rtc_halted", d, 32'd5);
    @(posedge clk); #1 halt = 1'b0;
    rtc_pulse();
    repeat (4) @(posedge clk);
    rd(16'hBFF8, d);
    chk("t5_rtc_resume", d, 32'd6);

    // Tick coincident with an mtime write, unmapped space, reset mid-count.
    sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if ((m_cnt % A_DIV) == A_DIV - 1) break;
    end
    avalid = 1'b1; addr = 16'hBFF8; wdata = 32'h100; wstrb = 4'hF;
    @(posedge clk); #1;
    avalid = 1'b0; wstrb = 4'b0;
    rd(16'hBFF8, d);
    chk("t6_write_wins", d, 32'h100);
    rd(16'h5000, d);
    chk("t6_unmapped", d, 32'h0);
    wr(16'h0014, 32'h1, 4'hF);
    rd(16'h0014, d);
    chk("t6_unmapped_hart", d, 32'h0);
    wr(16'h0000, 32'h1, 4'b0001);
    wr(16'h4008, 32'h0, 4'hF);
    wr(16'h400C, 32'h0, 4'hF);
    @(posedge clk); #1;
    chk("t6_mtip_pre", mtip_a, 4'b0010);
    chk("t6_msip_pre", msip_a, 4'b0101);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_mtip", mtip_a, 4'h0);
    chk("t6_rst_msip", msip_a, 4'h0);
    chk("t6_rst_ssip", ssip_a, 4'h0);
    chk("t6_rst_ready", ready_a, 1'b0);
    chk("t6_rst_b_mtip", mtip_b, 2'b00);
    #1 rst_n = 1'b1;
    rd(16'h4008, d);
    chk("t6_cmp_lo_ones", d, 32'hFFFF_FFFF);
    rd(16'h400C, d);
    chk("t6_cmp_hi_ones", d, 32'hFFFF_FFFF);
    rd(16'hBFFC, d);
    chk("t6_mtime_hi_zero", d, 32'h0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
